pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central sequencing unit for the 5-stage pipeline: drives PC/IF_ID enables, IF_ID flush and ID_EX bubble insertion.
- Keeps a 32-entry register scoreboard to stall dependent instructions in ID until the producer retires in WB.
- Runs a flush state machine on BranchTaken from EX and redirects the IF stage to the latched BranchTarget.
- Sits beside IF_STAGE and the ID stage; exposes a stall counter for bench/perf observation.

Parameters:
- FLUSH_CYCLES, 2, cycles IF_ID/ID_EX are squashed after a taken branch (legal 1..7)
- PC_W, 8, PC/BranchTarget width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  pipeline clock (single clock domain)
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  valid instruction present in ID
- id_rs  in  5  ID source register 1
- id_rt  in  5  ID source register 2
- id_uses_rs  in  1  instruction reads id_rs
- id_uses_rt  in  1  instruction reads id_rt
- id_writes  in  1  instruction writes id_rd
- id_rd  in  5  ID destination register
- BranchTaken  in  1  branch resolved taken in EX
- BranchTarget  in  PC_W  branch destination from EX
- wb_writes  in  1  WB retiring a register write this cycle
- wb_rd  in  5  WB destination register
- pc_en  out  1  PC may advance
- if_id_en  out  1  IF_ID register may load
- if_id_flush  out  1  clear IF_ID to NOP
- id_ex_bubble  out  1  load NOP into ID_EX
- pc_sel_branch  out  1  PC loads pc_target instead of PC+4
- pc_target  out  PC_W  latched branch target
- issue  out  1  ID instruction advances to EX this cycle
- busy_mask  out  32  scoreboard contents (bit n = reg n pending)
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst=1 at posedge): state=RUN, busy_mask=0, flush_cnt=0, pc_target=0, stall_cnt=0. Outputs during/after reset: pc_en=1, if_id_en=1, if_id_flush=0, id_ex_bubble=0, pc_sel_branch=0, issue=0 (issue is 0 while rst=1). Reset mid-flush or mid-stall aborts to RUN; no pending bit survives.
- States: RUN, STALL, FLUSH. Control outputs are combinational from registered state plus current ID/WB inputs; all state updates occur at posedge clk.
- hazard = id_valid & ((id_uses_rs & busy[id_rs] & id_rs!=0) | (id_uses_rt & busy[id_rt] & id_rt!=0)). A WB clear in the same cycle does not resolve the hazard (no bypass through the scoreboard); the stall lifts the following cycle.
- RUN/STALL, no BranchTaken: if hazard, the state is STALL, pc_en=0, if_id_en=0, id_ex_bubble=1, issue=0, and stall_cnt increments, saturating at all-ones. Otherwise the state is RUN, enables=1, and issue=id_valid.
- BranchTaken=1 in any state, including FLUSH, restarts the flush:
  - next state=FLUSH, flush_cnt=FLUSH_CYCLES-1, pc_target<=BranchTarget;
  - in that same cycle: issue=0, id_ex_bubble=1, if_id_flush=1;
  - BranchTaken has priority over hazard; stall_cnt does not increment.
- FLUSH:
  - first FLUSH cycle: pc_sel_branch=1, pc_en=1;
  - every FLUSH cycle: if_id_flush=1, id_ex_bubble=1, issue=0;
  - flush_cnt decrements each cycle; at flush_cnt=0 the next state is RUN.
  - Total squash window = 1 (BranchTaken cycle) + FLUSH_CYCLES.
- Scoreboard update per cycle:
  - set bit id_rd if issue & id_writes & id_rd!=0;
  - clear bit wb_rd if wb_writes.
  - Same register set and cleared in the same cycle: set wins (the new producer supersedes).
  - Bit 0 is never set.
- wb_writes to a non-busy register is ignored (no error).

Test Plan:
- Reset: hold rst 2 cycles with id_valid=1, BranchTaken=1 -> busy_mask=0, stall_cnt=0, issue=0; first cycle after release: state RUN, pc_en=1.
- Load-use: issue id_rd=5, id_writes=1; next cycle ID reads id_rs=5 -> busy_mask=0x20, pc_en=0, id_ex_bubble=1 for 3 cycles. wb_writes/wb_rd=5 pulse -> issue=1 the cycle after, stall_cnt=3.
- R0 immunity: issue id_rd=0 with id_writes=1, then read id_rs=0 -> busy_mask stays 0, no stall.
- Branch: BranchTaken=1, BranchTarget=16 -> pc_target=16, pc_sel_branch=1 one cycle later, if_id_flush=1 for 3 consecutive cycles (FLUSH_CYCLES=2), then RUN with issue=id_valid.
- Branch over stall: a hazard is pending when BranchTaken=1 -> no stall_cnt increment, FLUSH entered, bubble asserted.
- Set/clear collision: wb_rd=7 clear and issue id_rd=7 in the same cycle -> busy_mask bit 7=1. Saturation: 65536+ forced stall cycles -> stall_cnt=0xFFFF.

Source files
------------

// File: rtl/pipeline_hazard_if.sv
// ID/EX/WB-facing signal bundle for the hazard controller.
// The pipeline side drives ID/WB/branch inputs; the controller drives the enables.
interface pipeline_hazard_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_writes;
    logic [4:0]       id_rd;
    logic             BranchTaken;
    logic [PC_W-1:0]  BranchTarget;
    logic             wb_writes;
    logic [4:0]       wb_rd;

    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pc_sel_branch;
    logic [PC_W-1:0]  pc_target;
    logic             issue;
    logic [31:0]      busy_mask;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_writes, id_rd,
               BranchTaken, BranchTarget, wb_writes, wb_rd,
        input  pc_en, if_id_en, if_id_flush, id_ex_bubble, pc_sel_branch,
               pc_target, issue, busy_mask, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_writes, id_rd,
               BranchTaken, BranchTarget, wb_writes, wb_rd,
        output pc_en, if_id_en, if_id_flush, id_ex_bubble, pc_sel_branch,
               pc_target, issue, busy_mask, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: register scoreboard stalls in ID, branch flush FSM,
// PC redirect to the latched target, and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int PC_W         = 8,
    parameter int CNT_W        = 16
) (
    input logic               clk,
    input logic               rst,
    pipeline_hazard_if.slave  bus
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    localparam logic [2:0] FC_LAST = 3'(FLUSH_CYCLES - 1);

    state_t           state, state_nxt;
    logic [2:0]       flush_cnt, flush_cnt_nxt;
    logic [31:0]      busy, busy_nxt;
    logic [PC_W-1:0]  pc_target;
    logic [CNT_W-1:0] stall_cnt;

    logic hazard;
    logic stall;
    logic pc_en, if_id_en, if_id_flush, id_ex_bubble, pc_sel_branch, issue;

    // No bypass: a WB clear this cycle does not hide the pending bit yet.
    assign hazard = bus.id_valid &
                    ((bus.id_uses_rs & busy[bus.id_rs] & (bus.id_rs != 5'd0)) |
                     (bus.id_uses_rt & busy[bus.id_rt] & (bus.id_rt != 5'd0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        if (bus.BranchTaken) begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = FC_LAST;
        end else if (state == FLUSH) begin
            if (flush_cnt == 3'd0) state_nxt = RUN;
            else                   flush_cnt_nxt = flush_cnt - 3'd1;
        end else begin
            state_nxt = hazard ? STALL : RUN;
        end
    end

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        pc_sel_branch = 1'b0;
        issue         = 1'b0;
        stall         = 1'b0;
        if (!rst) begin
            // The redirect lands on the first FLUSH cycle even if a new branch restarts it.
            pc_sel_branch = (state == FLUSH) && (flush_cnt == FC_LAST);
            if (bus.BranchTaken || state == FLUSH) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (hazard) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
                stall        = 1'b1;
            end else begin
                issue = bus.id_valid;
            end
        end
    end

    // New producer wins over a same-cycle retire of the same register.
    always_comb begin
        busy_nxt = busy;
        if (bus.wb_writes)             busy_nxt[bus.wb_rd] = 1'b0;
        if (issue && bus.id_writes)    busy_nxt[bus.id_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            pc_target <= '0;
            stall_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            if (bus.BranchTaken) pc_target <= bus.BranchTarget;
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.pc_en         = pc_en;
    assign bus.if_id_en      = if_id_en;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.id_ex_bubble  = id_ex_bubble;
    assign bus.pc_sel_branch = pc_sel_branch;
    assign bus.pc_target     = pc_target;
    assign bus.issue         = issue;
    assign bus.busy_mask     = busy;
    assign bus.stall_cnt     = stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a per-cycle reference model plus
// hand-computed checkpoints for load-use, R0, branch flush, collision and saturation.
module tb_pipeline_hazard_ctrl;
    localparam int FC = 2;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    pipeline_hazard_if #(.PC_W(8), .CNT_W(16)) bus ();

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .PC_W(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rs = 0;
        bus.id_uses_rt = 0; bus.id_writes = 0; bus.id_rd = 0; bus.BranchTaken = 0;
        bus.BranchTarget = 0; bus.wb_writes = 0; bus.wb_rd = 0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic produce(input logic [4:0] rd);
        idle(); bus.id_valid = 1; bus.id_writes = 1; bus.id_rd = rd;
    endtask

    task automatic consume(input logic [4:0] rs);
        idle(); bus.id_valid = 1; bus.id_uses_rs = 1; bus.id_rs = rs;
    endtask

    // Reference model: pending set as a bit array, flush as "cycles left to squash".
    initial begin : model
        bit          mb [32];
        int          fl;
        int          sc;
        logic [7:0]  tgt;
        bit          haz, stl, ep, ee, ef, eb, es, ei;
        logic [31:0] bm;
        fl = 0; sc = 0; tgt = 0;
        foreach (mb[i]) mb[i] = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            ep = 1; ee = 1; ef = 0; eb = 0; es = 0; ei = 0; stl = 0;
            haz = bus.id_valid &&
                  ((bus.id_uses_rs && bus.id_rs != 0 && mb[bus.id_rs]) ||
                   (bus.id_uses_rt && bus.id_rt != 0 && mb[bus.id_rt]));
            if (!rst) begin
                es = (fl == FC);
                if (bus.BranchTaken || fl > 0) begin
                    ef = 1; eb = 1;
                end else if (haz) begin
                    ep = 0; ee = 0; eb = 1; stl = 1;
                end else begin
                    ei = bus.id_valid;
                end
            end
            foreach (mb[i]) bm[i] = mb[i];
            chk("m_pc_en",         32'(bus.pc_en),         32'(ep));
            chk("m_if_id_en",      32'(bus.if_id_en),      32'(ee));
            chk("m_if_id_flush",   32'(bus.if_id_flush),   32'(ef));
            chk("m_id_ex_bubble",  32'(bus.id_ex_bubble),  32'(eb));
            chk("m_pc_sel_branch", 32'(bus.pc_sel_branch), 32'(es));
            chk("m_issue",         32'(bus.issue),         32'(ei));
            chk("m_busy_mask",     bus.busy_mask,          bm);
            chk("m_stall_cnt",     32'(bus.stall_cnt),     32'(sc));
            chk("m_pc_target",     32'(bus.pc_target),     32'(tgt));
            if (rst) begin
                foreach (mb[i]) mb[i] = 0;
                fl = 0; sc = 0; tgt = 0;
            end else begin
                if (stl && sc < 65535) sc++;
                if (bus.wb_writes) mb[bus.wb_rd] = 0;
                if (ei && bus.id_writes && bus.id_rd != 0) mb[bus.id_rd] = 1;
                if (bus.BranchTaken) begin
                    fl = FC; tgt = bus.BranchTarget;
                end else if (fl > 0) begin
                    fl--;
                end
            end
        end
    end

    initial begin : stim
        idle();
        rst = 1;
        bus.id_valid = 1; bus.BranchTaken = 1; bus.BranchTarget = 8'h33;
        bus.id_writes = 1; bus.id_rd = 5'd3;
        @(posedge clk); @(negedge clk);
        chk("rst_issue", 32'(bus.issue), 32'd0);
        chk("rst_busy", bus.busy_mask, 32'd0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        cyc();
        rst = 0; idle();
        @(negedge clk);
        chk("post_rst_pc_en", 32'(bus.pc_en), 32'd1);
        chk("post_rst_flush", 32'(bus.if_id_flush), 32'd0);

        // Load-use on r5: three stall cycles, WB retires on the third.
        cyc(); produce(5'd5);
        cyc(); consume(5'd5);
        @(negedge clk);
        chk("lu_busy", bus.busy_mask, 32'h20);
        chk("lu_pc_en", 32'(bus.pc_en), 32'd0);
        chk("lu_bubble", 32'(bus.id_ex_bubble), 32'd1);
        cyc();
        cyc(); bus.wb_writes = 1; bus.wb_rd = 5'd5;
        @(negedge clk);
        chk("lu_still_stall", 32'(bus.issue), 32'd0);
        cyc(); bus.wb_writes = 0;
        @(negedge clk);
        chk("lu_issue", 32'(bus.issue), 32'd1);
        chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd3);

        // R0 is never tracked.
        cyc(); produce(5'd0);
        cyc(); consume(5'd0);
        @(negedge clk);
        chk("r0_busy", bus.busy_mask, 32'd0);
        chk("r0_pc_en", 32'(bus.pc_en), 32'd1);

        // Taken branch: 1 + FC squash cycles, redirect on the first FLUSH cycle.
        cyc(); idle(); bus.id_valid = 1; bus.BranchTaken = 1; bus.BranchTarget = 8'd16;
        @(negedge clk);
        chk("br_flush0", 32'(bus.if_id_flush), 32'd1);
        chk("br_issue0", 32'(bus.issue), 32'd0);
        cyc(); bus.BranchTaken = 0;
        @(negedge clk);
        chk("br_target", 32'(bus.pc_target), 32'd16);
        chk("br_sel", 32'(bus.pc_sel_branch), 32'd1);
        chk("br_flush1", 32'(bus.if_id_flush), 32'd1);
        cyc();
        @(negedge clk);
        chk("br_flush2", 32'(bus.if_id_flush), 32'd1);
        chk("br_sel2", 32'(bus.pc_sel_branch), 32'd0);
        cyc();
        @(negedge clk);
        chk("br_run_flush", 32'(bus.if_id_flush), 32'd0);
        chk("br_run_issue", 32'(bus.issue), 32'd1);

        // Branch arrives while r9 hazard is stalling ID.
        cyc(); produce(5'd9);
        cyc(); consume(5'd9);
        @(negedge clk);
        chk("bos_stall", 32'(bus.pc_en), 32'd0);
        cyc(); bus.BranchTaken = 1; bus.BranchTarget = 8'h40;
        @(negedge clk);
        chk("bos_bubble", 32'(bus.id_ex_bubble), 32'd1);
        chk("bos_flush", 32'(bus.if_id_flush), 32'd1);
        chk("bos_pc_en", 32'(bus.pc_en), 32'd1);
        cyc(); bus.BranchTaken = 0;
        @(negedge clk);
        chk("bos_stall_cnt", 32'(bus.stall_cnt), 32'd4);
        chk("bos_target", 32'(bus.pc_target), 32'h40);
        cyc();
        cyc(); idle(); bus.wb_writes = 1; bus.wb_rd = 5'd9;
        cyc(); idle();

        // Set/clear collision on r7: the new producer wins.
        cyc(); produce(5'd7);
        cyc(); produce(5'd7); bus.wb_writes = 1; bus.wb_rd = 5'd7;
        cyc(); idle();
        @(negedge clk);
        chk("coll_busy", bus.busy_mask, 32'h80);
        cyc(); bus.wb_writes = 1; bus.wb_rd = 5'd7;
        cyc(); idle();

        // Saturation: hold a hazard on r3 well past 2^16 stall cycles.
        cyc(); produce(5'd3);
        cyc(); consume(5'd3);
        repeat (65540) cyc();
        @(negedge clk);
        chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'h0000FFFF);
        chk("sat_pc_en", 32'(bus.pc_en), 32'd0);
        cyc(); idle(); bus.wb_writes = 1; bus.wb_rd = 5'd3;
        cyc(); idle();
        cyc();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
